// File: rtl/mem_access_unit_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store unit.
// Opcode constants, FSM states, access-size encoding and lane helpers.
package mem_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

  typedef struct packed {
    logic  is_mem;
    logic  is_load;
    size_t size;
    logic  sign_ext;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d.is_mem   = 1'b1;
    d.is_load  = 1'b1;
    d.size     = WORD;
    d.sign_ext = 1'b0;
    case (op)
      OP_LW:  d.size = WORD;
      OP_LB:  begin d.size = BYTE; d.sign_ext = 1'b1; end
      OP_LBU: d.size = BYTE;
      OP_LH:  begin d.size = HALF; d.sign_ext = 1'b1; end
      OP_LHU: d.size = HALF;
      OP_SW:  begin d.is_load = 1'b0; d.size = WORD; end
      OP_SB:  begin d.is_load = 1'b0; d.size = BYTE; end
      OP_SH:  begin d.is_load = 1'b0; d.size = HALF; end
      default: begin d.is_mem = 1'b0; d.is_load = 1'b0; end
    endcase
    return d;
  endfunction

  function automatic logic is_aligned(input size_t size, input logic [1:0] off);
    case (size)
      BYTE:    return 1'b1;
      HALF:    return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input size_t size, input logic [1:0] off);
    case (size)
      BYTE:    return 4'b0001 << off;
      HALF:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate store data across every lane so the responder can apply be directly.
  function automatic logic [31:0] lane_data(input size_t size, input logic [31:0] w);
    case (size)
      BYTE:    return {4{w[7:0]}};
      HALF:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/grant/response bus between the load/store unit and data memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] ext
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size)
      BYTE:    ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      HALF:    ext = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: ext = mem_rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: decode, alignment check, bus handshake,
// load extraction, and pipeline stall until the access completes.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       ir,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              adel,
  output logic              ades,
  mem_access_unit_if.master bus
);
  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  size_t             size_q, size_d;
  logic              sign_q, sign_d;
  logic              load_q, load_d;
  logic [31:0]       rdata_q, rdata_d;

  mem_op_t     dec;
  logic        aligned;
  logic        accept;
  logic [31:0] extracted;
  logic        unused_ir;

  assign dec       = decode_op(ir[31:26]);
  assign aligned   = is_aligned(dec.size, addr[1:0]);
  assign accept    = (state_q == IDLE) && start && dec.is_mem && aligned;
  assign unused_ir = ^ir[25:0];

  load_extract u_extract (
    .mem_rdata (bus.mem_rdata),
    .off       (off_q),
    .size      (size_q),
    .sign_ext  (sign_q),
    .ext       (extracted)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    size_d  = size_q;
    sign_d  = sign_q;
    load_d  = load_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = ~dec.is_load;
          be_d    = byte_en(dec.size, addr[1:0]);
          addr_d  = {addr[ADDR_W-1:2], 2'b00};
          wdata_d = dec.is_load ? 32'h0 : lane_data(dec.size, wdata);
          off_d   = addr[1:0];
          size_d  = dec.size;
          sign_d  = dec.sign_ext;
          load_d  = dec.is_load;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          req_d   = 1'b0;
          state_d = load_q ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = extracted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Misalignment is only reported for an instruction actually presented in IDLE.
  always_comb begin
    stall       = accept || (state_q == REQ) || (state_q == WAIT);
    rdata_valid = (state_q == DONE) && load_q;
    adel        = (state_q == IDLE) && start && dec.is_mem &&  dec.is_load && !aligned;
    ades        = (state_q == IDLE) && start && dec.is_mem && !dec.is_load && !aligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      off_q   <= 2'b00;
      size_q  <= BYTE;
      sign_q  <= 1'b0;
      load_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      load_q  <= load_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign rdata         = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] ir;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        adel;
  logic        ades;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rdata = 32'h0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ir          (ir),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .adel        (adel),
    .ades        (ades),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: opcode table and arithmetic lane rules.
  task automatic props(input logic [5:0] opc, output bit m, output bit ld, output int nb, output bit sg);
    m = 1; ld = 1; nb = 4; sg = 0;
    case (opc)
      6'b100011: nb = 4;
      6'b100000: begin nb = 1; sg = 1; end
      6'b100100: nb = 1;
      6'b100001: begin nb = 2; sg = 1; end
      6'b100101: nb = 2;
      6'b101011: begin ld = 0; nb = 4; end
      6'b101000: begin ld = 0; nb = 1; end
      6'b101001: begin ld = 0; nb = 2; end
      default:   begin m = 0; ld = 0; end
    endcase
  endtask

  function automatic logic [3:0] exp_be(input int nb, input logic [31:0] a);
    int k;
    k = a % 4;
    if (nb == 4) return 4'hF;
    if (nb == 2) return (k >= 2) ? 4'hC : 4'h3;
    return 4'(1 << k);
  endfunction

  function automatic logic [31:0] exp_wdata(input int nb, input logic [31:0] wd);
    if (nb == 1) return (wd % 256) * 32'h01010101;
    if (nb == 2) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                           input int nb, input bit sg);
    longint v;
    int     sh;
    if (nb == 4) return word;
    sh = (nb == 1) ? (a % 4) * 8 : ((a % 4) / 2) * 16;
    v  = (longint'(word) >> sh) % (longint'(1) << (8 * nb));
    if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  // One instruction presented in MEM; gd = cycles gnt is withheld, rd = extra cycles before rvalid.
  task automatic run_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] wd,
                        input int gd, input int rd, input logic [31:0] word);
    bit m, ld, sg, ok;
    int nb, stalls, exp_stalls;
    props(opc, m, ld, nb, sg);
    ok = m && ((a % nb) == 0);
    stalls = 0;
    @(posedge clk); #1;
    start = 1'b1; ir = {opc, 26'($urandom)}; addr = a; wdata = wd;
    #1;
    chk("accept_stall", 32'(stall), 32'(ok));
    chk("adel", 32'(adel), 32'(m && ld && !ok));
    chk("ades", 32'(ades), 32'(m && !ld && !ok));
    chk("idle_req", 32'(bus.mem_req), 32'h0);
    if (stall) stalls++;
    @(posedge clk); #1;
    start = 1'b0; ir = $urandom; addr = $urandom; wdata = $urandom;
    #1;
    if (!ok) begin
      chk("no_req", 32'(bus.mem_req), 32'h0);
      chk("no_stall", 32'(stall), 32'h0);
      $display("[TB] op=%b addr=%h rejected adel=%0d ades=%0d", opc, a, m && ld, m && !ld);
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      chk("req", 32'(bus.mem_req), 32'h1);
      chk("we", 32'(bus.mem_we), 32'(!ld));
      chk("be", 32'(bus.mem_be), 32'(exp_be(nb, a)));
      chk("maddr", bus.mem_addr, a - (a % 4));
      if (!ld) chk("mwdata", bus.mem_wdata, exp_wdata(nb, wd));
      chk("req_stall", 32'(stall), 32'h1);
      if (stall) stalls++;
      bus.mem_gnt    = (i == gd);
      bus.mem_rvalid = (i < gd) ? 1'($urandom) : 1'b0;
      bus.mem_rdata  = $urandom;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      #1;
    end
    if (ld) begin
      for (int j = 0; j <= rd; j++) begin
        chk("wait_req", 32'(bus.mem_req), 32'h0);
        chk("wait_stall", 32'(stall), 32'h1);
        chk("wait_rv", 32'(rdata_valid), 32'h0);
        if (stall) stalls++;
        bus.mem_rvalid = (j == rd);
        bus.mem_rdata  = (j == rd) ? word : $urandom;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        #1;
      end
      last_rdata = exp_load(word, a, nb, sg);
    end
    chk("done_stall", 32'(stall), 32'h0);
    chk("done_rv", 32'(rdata_valid), 32'(ld));
    chk("done_rdata", rdata, last_rdata);
    chk("stall_cycles", 32'(stalls), 32'(1 + (gd + 1) + (ld ? rd + 1 : 0)));
    @(posedge clk); #1;
    chk("idle_rv", 32'(rdata_valid), 32'h0);
    chk("held_rdata", rdata, last_rdata);
    $display("[TB] op=%b addr=%h wd=%h gd=%0d rd=%0d rdata=%h", opc, a, wd, gd, rd, rdata);
  endtask

  initial begin
    logic [5:0] ops [11];
    ops = '{6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
            6'b101011, 6'b101000, 6'b101001, 6'b000000, 6'b001111, 6'b101111};

    reset = 1'b1; start = 1'b0; ir = 32'h0; addr = 32'h0; wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'h0);
    chk("rst_be", 32'(bus.mem_be), 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags", {28'h0, rdata_valid, stall, adel, ades}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(6'b100011, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF);
    chk("tp_lw", rdata, 32'hDEADBEEF);
    run_op(6'b100000, 32'h13, 32'h0, 0, 0, 32'h80112233);
    chk("tp_lb", rdata, 32'hFFFFFF80);
    run_op(6'b100100, 32'h13, 32'h0, 0, 0, 32'h80112233);
    chk("tp_lbu", rdata, 32'h00000080);
    run_op(6'b101001, 32'h22, 32'h1234ABCD, 0, 0, 32'h0);
    run_op(6'b100001, 32'h21, 32'h0, 0, 0, 32'h0);
    run_op(6'b101011, 32'h02, 32'h0, 0, 0, 32'h0);
    run_op(6'b101000, 32'h47, 32'hCAFE5A3C, 5, 0, 32'h0);

    for (int t = 0; t < 60; t++) begin
      run_op(ops[$urandom_range(0, 10)], $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset during REQ drops mem_req at once.
    @(posedge clk); #1;
    start = 1'b1; ir = {6'b100011, 26'h0}; addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    #1 chk("rreq_req", 32'(bus.mem_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("rreq_req_drop", 32'(bus.mem_req), 32'h0);
    chk("rreq_stall", 32'(stall), 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Reset during WAIT abandons the load; a late rvalid is ignored.
    @(posedge clk); #1;
    start = 1'b1; ir = {6'b100011, 26'h0}; addr = 32'h80;
    @(posedge clk); #1;
    start = 1'b0; bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    #1 chk("rwait_stall_pre", 32'(stall), 32'h1);
    reset = 1'b1;
    #1;
    chk("rwait_req", 32'(bus.mem_req), 32'h0);
    chk("rwait_stall", 32'(stall), 32'h0);
    chk("rwait_rdata", rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13572468;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    #1 chk("late_rv", 32'(rdata_valid), 32'h0);
    @(posedge clk); #1;
    chk("late_rv2", 32'(rdata_valid), 32'h0);
    chk("late_rdata", rdata, 32'h0);
    $display("[TB] reset during REQ/WAIT abandoned access");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store initiator for the pipelined MIPS core. It decodes the memory opcode of the instruction in MEM, checks alignment, and drives a request/grant/response handshake toward the data memory. It forms byte enables and lane-replicated write data, then extracts and sign- or zero-extends load data. It stalls the pipeline until the access completes.

## Interface
- ADDR_W, 32, address width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  MEM stage holds a valid instruction (level; sampled only in IDLE)
- ir  in  32  instruction in MEM; opcode = ir[31:26]
- addr  in  ADDR_W  effective address
- wdata  in  32  rt value for stores
- stall  out  1  freeze IF..MEM stages
- rdata  out  32  extended load result (held until next load completes)
- rdata_valid  out  1  one-cycle pulse with rdata
- adel / ades  out  1  misaligned load / store (combinational)
- mem_req  out  1  request valid
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables, lane k = bits 8k+7:8k (little-endian)
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  responder accepts request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  full word read

## Operation
- Opcodes: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001; any other opcode is not a memory op.
- Alignment: word ops need addr[1:0]=00; half ops need addr[0]=0; byte ops always aligned.
- mem_be: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111; loads use the same be.
- mem_wdata: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
- Load extract: lb/lbu select byte addr[1:0]; lh/lhu select half addr[1]; lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- FSM states:
  - IDLE: on start & mem op & aligned, register req fields and go to REQ. On start & misaligned, pulse adel (load) or ades (store) the same cycle, issue no request, and stay. A non-memory op or no start stays.
  - REQ: mem_req=1; on mem_gnt a load goes to WAIT and a store goes to DONE.
  - WAIT: on mem_rvalid capture the extracted mem_rdata into rdata and go to DONE.
  - DONE: rdata_valid=1 if load; go to IDLE unconditionally; start is ignored.
- stall = (IDLE & start & mem op & aligned) | REQ | WAIT. stall is 0 in DONE, so the pipeline advances on the DONE edge.

## Timing
- Reset values: state IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rdata = 0; rdata_valid, stall, adel, ades = 0.
- Reset mid-operation drops mem_req asynchronously and abandons the access. A later mem_rvalid is ignored.
- mem_req, mem_we, mem_be, mem_addr and mem_wdata are registered and held stable from REQ entry until the mem_gnt cycle.
- The responder asserts mem_rvalid no earlier than the cycle after mem_gnt. mem_rvalid outside WAIT is ignored.
- Minimum load with immediate gnt and rvalid: accept cycle 0, REQ cycle 1, WAIT cycle 2, DONE cycle 3. stall is high in cycles 0–2.
- Minimum store: accept cycle 0, REQ cycle 1, DONE cycle 2.
- mem_gnt held low keeps the unit in REQ indefinitely with stall high; there is no timeout.

## Structure
- Shared package mem_pkg holds:
  - opcode localparams
  - state enum {IDLE, REQ, WAIT, DONE}
  - access-size encoding (BYTE, HALF, WORD) and a signed flag
- Sub-module load_extract (combinational): inputs mem_rdata, addr[1:0], size, signed; output 32-bit extended value.

## Test plan
- lw at 0x10, gnt at REQ, rvalid next cycle with 0xDEADBEEF -> rdata=0xDEADBEEF, rdata_valid pulse in cycle 3, stall high for exactly 3 cycles.
- lb at 0x13 with rdata 0x80112233 -> be=1000, rdata=0xFFFFFF80; lbu at the same address -> 0x00000080.
- sh at 0x22 with wdata 0x1234ABCD -> mem_we=1, be=1100, mem_addr=0x20, mem_wdata=0xABCDABCD, no rdata_valid.
- lh at 0x21 -> adel=1 that cycle, mem_req never asserts, stall=0; sw at 0x02 -> ades=1.
- sb with mem_gnt withheld 5 cycles -> mem_req, mem_addr, mem_be and mem_wdata stay constant and stall stays high throughout; DONE follows the cycle after gnt.
- reset asserted while in WAIT -> mem_req=0 and stall=0 immediately; a later mem_rvalid produces no rdata_valid.
